// File: rtl/usb_stream_fifo.sv
// Single-clock valid/ready FIFO with first-word fall-through output, fill level,
// full/empty flags and a synchronous flush; buffers words coming out of the CDC stage.
module usb_stream_fifo #(
    parameter  int unsigned DATA_WID = 8,
    parameter  int unsigned DEPTH    = 8,
    localparam int unsigned CNT_WID  = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [DATA_WID-1:0] data_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [DATA_WID-1:0] data_o,
    output logic [CNT_WID-1:0]  fill_o,
    output logic                empty_o,
    output logic                full_o
);

    localparam int unsigned IDX_WID = CNT_WID - 1;

    logic [DATA_WID-1:0] mem [DEPTH];
    logic [CNT_WID-1:0]  wr_ptr;
    logic [CNT_WID-1:0]  rd_ptr;
    logic                push;
    logic                pop;

    // Flags decode straight from the registered pointers; MSB is the wrap bit.
    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr == {~rd_ptr[CNT_WID-1], rd_ptr[IDX_WID-1:0]});
    assign fill_o  = wr_ptr - rd_ptr;

    // ready_o is held low during reset so no word is taken before pointers are valid.
    assign ready_o = ~full_o & rst_n;
    assign valid_o = ~empty_o;
    assign data_o  = mem[rd_ptr[IDX_WID-1:0]];

    // Flush overrides both sides; words offered in the flush cycle are dropped.
    assign push = valid_i & ready_o & ~flush_i;
    assign pop  = valid_o & ready_i & ~flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + CNT_WID'(1);
            if (pop)  rd_ptr <= rd_ptr + CNT_WID'(1);
        end
    end

    // Storage is deliberately not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[IDX_WID-1:0]] <= data_i;
    end

endmodule
